// File: rtl/rsa_pkg.sv
// Shared constants and state encoding for the RSA decrypt block.
package rsa_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    localparam int PROD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_N = 16'd3233;
    localparam logic [WORD_W-1:0] DEFAULT_E = 16'd17;
    localparam logic [WORD_W-1:0] DEFAULT_D = 16'd2753;

    typedef enum logic [2:0] {
        S_IDLE, S_REDUCE, S_MUL, S_MUL_MOD, S_SQR, S_SQR_MOD, S_DONE
    } state_t;
endpackage

// File: rtl/rsa_mod_mult.sv
// Two-cycle modular multiply: product registered in cycle 1, remainder valid in cycle 2.
module rsa_mod_mult
    import rsa_pkg::*;
(
    input  logic              clk,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] n,
    output logic [WORD_W-1:0] rem
);
    logic [PROD_W-1:0] prod_q;
    logic [PROD_W-1:0] divisor;

    always_ff @(posedge clk) begin
        prod_q <= PROD_W'(a) * PROD_W'(b);
    end

    // n == 0 only reaches here on the mod_error path, where rem is discarded.
    assign divisor = (n == '0) ? PROD_W'(1) : PROD_W'(n);
    assign rem     = WORD_W'(prod_q % divisor);
endmodule

// File: rtl/rsa_decrypt.sv
// Constant-time RSA decryption m = c^d mod n, right-to-left square-and-multiply over 16 exponent bits.
module rsa_decrypt
    import rsa_pkg::*;
#(
    parameter logic [15:0] DEFAULT_N = rsa_pkg::DEFAULT_N,
    parameter logic [15:0] DEFAULT_D = rsa_pkg::DEFAULT_D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic        update_d,
    input  logic        update_n,
    input  logic        start,
    input  logic [15:0] ciphertext,
    output logic        busy,
    output logic        done,
    output logic [7:0]  plaintext,
    output logic        range_error,
    output logic        mod_error
);
    state_t            state;
    logic [WORD_W-1:0] n_reg, d_reg, n_snap, d_snap;
    logic [WORD_W-1:0] result, base;
    logic [3:0]        bit_cnt;
    logic [WORD_W-1:0] mm_a, mm_b, mm_rem;

    // In IDLE the multiplier is fed c*1 so REDUCE can read c % n one cycle later.
    always_comb begin
        mm_a = result;
        mm_b = d_snap[bit_cnt] ? base : WORD_W'(1);
        case (state)
            S_IDLE: begin
                mm_a = ciphertext;
                mm_b = WORD_W'(1);
            end
            S_SQR: begin
                mm_a = base;
                mm_b = base;
            end
            default: ;
        endcase
    end

    rsa_mod_mult u_mod_mult (
        .clk (clk),
        .a   (mm_a),
        .b   (mm_b),
        .n   (n_snap),
        .rem (mm_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            n_reg       <= DEFAULT_N;
            d_reg       <= DEFAULT_D;
            n_snap      <= '0;
            d_snap      <= '0;
            result      <= '0;
            base        <= '0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            plaintext   <= '0;
            range_error <= 1'b0;
            mod_error   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (update_d) d_reg <= data;
                    if (update_n) n_reg <= data;
                    if (start) begin
                        n_snap  <= n_reg;
                        d_snap  <= d_reg;
                        result  <= WORD_W'(1);
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    if (n_snap < WORD_W'(2)) begin
                        plaintext   <= '0;
                        range_error <= 1'b0;
                        mod_error   <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        base  <= mm_rem;
                        state <= S_MUL;
                    end
                end
                S_MUL:     state <= S_MUL_MOD;
                S_MUL_MOD: begin
                    result <= mm_rem;
                    state  <= S_SQR;
                end
                S_SQR:     state <= S_SQR_MOD;
                S_SQR_MOD: begin
                    base    <= mm_rem;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        plaintext   <= result[BYTE_W-1:0];
                        range_error <= (result > WORD_W'(255));
                        mod_error   <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        state <= S_MUL;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_decrypt.sv
// Directed bench for rsa_decrypt: latency, results, error flags, busy lockout and reset abort.
module tb_rsa_decrypt;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic        update_d, update_n, start;
    logic [15:0] ciphertext;
    logic        busy, done, range_error, mod_error;
    logic [7:0]  plaintext;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rsa_decrypt dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .update_d    (update_d),
        .update_n    (update_n),
        .start       (start),
        .ciphertext  (ciphertext),
        .busy        (busy),
        .done        (done),
        .plaintext   (plaintext),
        .range_error (range_error),
        .mod_error   (mod_error)
    );

    task automatic do_update(input logic un, input logic ud, input logic [15:0] v);
        @(negedge clk);
        update_n = un; update_d = ud; data = v;
        @(negedge clk);
        update_n = 1'b0; update_d = 1'b0;
    endtask

    // Start a run; k counts cycles after the start-sample cycle T.
    // poke_k: assert start+update_d(data=1) in that cycle; abort_k: assert rst in that cycle.
    task automatic run_op(input logic [15:0] c, input logic un, input logic [15:0] uv,
                          input int busy_end, input int poke_k, input int abort_k,
                          output int done_at, output int n_done, output int busy_bad);
        int limit;
        limit = busy_end + 4;
        @(negedge clk);
        start = 1'b1; ciphertext = c; update_n = un; data = uv;
        done_at = -1; n_done = 0; busy_bad = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            start = 1'b0; update_n = 1'b0; update_d = 1'b0; rst = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            if (busy !== (k <= busy_end)) busy_bad++;
            if (k == poke_k) begin
                start = 1'b1; ciphertext = 16'd7; update_d = 1'b1; data = 16'd1;
            end
            if (k == abort_k) rst = 1'b1;
        end
    endtask

    task automatic check_run(input string name, input logic [15:0] c, input int lat,
                             input logic [7:0] exp_pt, input logic exp_rng, input logic exp_mod);
        int da, nd, bb;
        run_op(c, 1'b0, 16'd0, lat, -1, -1, da, nd, bb);
        checks++; if (da !== lat || nd !== 1) begin errors++;
            $display("FAIL %s latency: done_at=%0d count=%0d required %0d/1", name, da, nd, lat); end
        checks++; if (bb !== 0) begin errors++;
            $display("FAIL %s busy: %0d bad cycles, required 0", name, bb); end
        checks++; if (plaintext !== exp_pt) begin errors++;
            $display("FAIL %s plaintext: got %0d required %0d", name, plaintext, exp_pt); end
        checks++; if (range_error !== exp_rng || mod_error !== exp_mod) begin errors++;
            $display("FAIL %s flags: range=%b mod=%b required %b %b", name, range_error, mod_error, exp_rng, exp_mod); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; update_d = 0; update_n = 0; data = 0; ciphertext = 0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, plaintext, range_error, mod_error} !== 12'd0) begin errors++;
            $display("FAIL reset outputs: busy=%b done=%b pt=%0d rng=%b mod=%b required all 0",
                     busy, done, plaintext, range_error, mod_error); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        check_run("basic_2790", 16'd2790, 66, 8'd65, 1'b0, 1'b0);
    endtask

    task automatic test_edge_values();
        check_run("c0", 16'd0, 66, 8'd0, 1'b0, 1'b0);
        check_run("c1", 16'd1, 66, 8'd1, 1'b0, 1'b0);
        check_run("c6023", 16'd6023, 66, 8'd65, 1'b0, 1'b0);
    endtask

    task automatic test_mod_error();
        do_update(1'b1, 1'b0, 16'd1);
        check_run("n1", 16'd2790, 2, 8'd0, 1'b0, 1'b1);
        do_update(1'b1, 1'b0, 16'd3233);
        check_run("n_restored", 16'd2790, 66, 8'd65, 1'b0, 1'b0);
    endtask

    task automatic test_update_d();
        do_update(1'b0, 1'b1, 16'd1);
        check_run("d1_c300", 16'd300, 66, 8'd44, 1'b1, 1'b0);
        do_update(1'b0, 1'b1, 16'd2753);
    endtask

    task automatic test_same_cycle();
        int da, nd, bb;
        run_op(16'd2790, 1'b1, 16'd1, 66, -1, -1, da, nd, bb);
        checks++; if (da !== 66 || plaintext !== 8'd65 || mod_error !== 1'b0) begin errors++;
            $display("FAIL same_cycle old_n: done_at=%0d pt=%0d mod=%b required 66/65/0", da, plaintext, mod_error); end
        check_run("same_cycle new_n", 16'd5, 2, 8'd0, 1'b0, 1'b1);
        do_update(1'b1, 1'b0, 16'd3233);
    endtask

    task automatic test_busy_ignore();
        int da, nd, bb;
        run_op(16'd2790, 1'b0, 16'd0, 66, 10, -1, da, nd, bb);
        checks++; if (nd !== 1 || da !== 66 || bb !== 0) begin errors++;
            $display("FAIL busy_ignore done: count=%0d at=%0d busy_bad=%0d required 1/66/0", nd, da, bb); end
        checks++; if (plaintext !== 8'd65) begin errors++;
            $display("FAIL busy_ignore plaintext: got %0d required 65", plaintext); end
        check_run("busy_ignore d_kept", 16'd2790, 66, 8'd65, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        int da, nd, bb;
        do_update(1'b1, 1'b1, 16'd1);
        do_update(1'b1, 1'b0, 16'd3233);
        run_op(16'd2790, 1'b0, 16'd0, 30, -1, 30, da, nd, bb);
        checks++; if (nd !== 0 || bb !== 0) begin errors++;
            $display("FAIL abort: dones=%0d busy_bad=%0d required 0/0", nd, bb); end
        checks++; if (plaintext !== 8'd0 || mod_error !== 1'b0) begin errors++;
            $display("FAIL abort outputs: pt=%0d mod=%b required 0/0", plaintext, mod_error); end
        check_run("abort defaults", 16'd2790, 66, 8'd65, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge_values();
        test_mod_error();
        test_update_d();
        test_same_cycle();
        test_busy_ignore();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
